hilo_muldiv_ctrl: RTL and testbench
===================================

Name: hilo_muldiv_ctrl

Overview:
- Sequences every write to the HI/LO register pair for MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Runs an iterative 32-step shift-add multiplier and a 32-step restoring divider.
- Sits in the EX stage. It stalls the pipeline while an operation is in flight and drives the HI/LO write-enable and write-data inputs of the register file.

Parameters:
- ITER, 32, number of iteration cycles for multiply and divide (fixed for 32-bit operands).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  request valid; sampled only in IDLE.
- op  in  3  001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO; 000/111 no operation.
- src1  in  32  multiplicand / dividend / MTHI-MTLO data.
- src2  in  32  multiplier / divisor.
- flush  in  1  pipeline flush; aborts any uncommitted operation.
- stall  out  1  pipeline stall request.
- busy  out  1  high in MUL or DIV state.
- hi_we  out  1  HI write enable, one-cycle pulse.
- hi_wdata  out  32  HI write data.
- lo_we  out  1  LO write enable, one-cycle pulse.
- lo_wdata  out  32  LO write data.

Behaviour:
- Reset: asynchronous on resetn low. State goes to IDLE. Counter, accumulators, hi_we, lo_we, hi_wdata and lo_wdata are all 0. busy and stall are 0.
- States: IDLE, MUL, DIV, WB.
- Accept: start=1, flush=0 in IDLE with a valid op (cycle N). Operands are latched at N.
  - start during MUL/DIV/WB is ignored.
  - start with flush=1 is ignored.
  - Reserved ops are ignored with no state change.
- MTHI/MTLO: stay in IDLE. Registered hi_we (or lo_we)=1 in cycle N+1 with wdata=src1 from cycle N. The other enable stays 0. stall never asserts.
- MULT/MULTU: IDLE->MUL at N.
  - Signed: operate on absolute values. MULTU: operate on raw values.
  - One shift-add step per cycle in cycles N+1..N+32 (5-bit counter, 0..31).
  - After step 31, go to WB. Signed result is 64-bit negated when operand signs differ.
- DIV/DIVU: IDLE->DIV at N.
  - 32 restoring steps in cycles N+1..N+32 on magnitudes (signed) or raw values (unsigned).
  - Quotient sign = XOR of operand signs. Remainder sign = dividend sign.
  - 0x80000000 / 0xFFFFFFFF (signed) gives LO=0x80000000, HI=0.
- Divide by zero: same latency. Result is HI=src1, LO=0xFFFFFFFF, for both signed and unsigned.
- WB: exactly one cycle (N+33).
  - hi_we=lo_we=1, hi_wdata=product[63:32] or remainder, lo_wdata=product[31:0] or quotient.
  - Then return to IDLE. A new start is accepted in the cycle after WB at the earliest.
- Write enables are 0 in every other cycle. wdata holds its last value when not written.
- stall: combinational.
  - 1 in the accept cycle of a MUL/DIV op (start & valid mul/div op & IDLE & !flush).
  - 1 in all MUL/DIV cycles.
  - 0 in WB and IDLE.
- busy: 1 in MUL and DIV states only.
- Flush:
  - flush=1 in MUL or DIV: next state IDLE, counter cleared, no HI/LO write.
  - flush in WB does not suppress the write; the operation has committed.
  - flush while IDLE cancels a same-cycle start, including MTHI/MTLO.
- Reset mid-operation: immediate return to IDLE with the reset values above. No write pulse appears afterward.

Test Plan:
- MULT src1=0xFFFFFFFE, src2=0x00000003 accepted at N:
  - stall=1 for N..N+32.
  - hi_we=lo_we=1 only at N+33, with HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- MULTU 0xFFFFFFFF×0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001 at N+33.
- DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 7/2 -> LO=3, HI=1.
- DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU 5/0 -> HI=0x00000005, LO=0xFFFFFFFF at N+33, no hang.
- MTHI 0x12345678 at N:
  - hi_we=1 at N+1 only, hi_wdata=0x12345678.
  - lo_we=0, stall=0 throughout.
  - Back-to-back MTLO at N+1 gives lo_we=1 at N+2.
- Abort and reset:
  - flush at iteration 10 of DIV: IDLE next cycle, no write pulses; new MULT accepted the following cycle completes normally.
  - resetn low at iteration 20 of MULT: all outputs 0 asynchronously, no write after release.

Source files
------------

// File: rtl/hilo_muldiv_ctrl.sv
// hilo_muldiv_ctrl: EX-stage sequencer for every HI/LO write.
// Runs a 32-step shift-add multiplier and a 32-step restoring divider, and
// handles single-cycle MTHI/MTLO writes.
// Ports:
//   clk, resetn          - clock, asynchronous active-low reset
//   start, op, src1/src2 - request (sampled in IDLE only), opcode, operands
//   flush                - aborts any uncommitted operation
//   stall (comb), busy   - pipeline stall request, MUL/DIV in flight
//   hi_we/hi_wdata, lo_we/lo_wdata - registered HI/LO write port
module hilo_muldiv_ctrl #(
  parameter int unsigned ITER = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  input  logic        flush,
  output logic        stall,
  output logic        busy,
  output logic        hi_we,
  output logic [31:0] hi_wdata,
  output logic        lo_we,
  output logic [31:0] lo_wdata
);

  localparam int unsigned W  = 32;
  localparam int unsigned CW = $clog2(ITER);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_WB} state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [2*W-1:0]  r_acc;     // mul: {partial, multiplier}; div: {remainder, quotient}
  logic [W-1:0]    r_opb;     // multiplicand / divisor magnitude
  logic [W-1:0]    r_src1;    // raw dividend, returned as HI on divide by zero
  logic            r_neg_q, r_neg_r, r_divz, r_busy;
  logic            r_hi_we, r_lo_we;
  logic [W-1:0]    r_hi_wdata, r_lo_wdata;

  logic            w_go, w_is_md, w_is_mul, w_signed, w_s1n, w_s2n, w_last;
  logic [W-1:0]    w_a_mag, w_b_mag;
  logic [W:0]      w_mul_sum;
  logic [2*W-1:0]  w_mul_acc, w_div_acc, w_step, w_prod;
  logic            w_div_ok;
  logic [W-1:0]    w_rem_sub, w_quo, w_rem, w_hi_res, w_lo_res;

  // Request decode and operand magnitudes for the signed ops
  assign w_go     = (r_state == S_IDLE) && start && !flush;
  assign w_is_md  = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  assign w_is_mul = (op == OP_MULT) || (op == OP_MULTU);
  assign w_signed = (op == OP_MULT) || (op == OP_DIV);
  assign w_s1n    = w_signed && src1[W-1];
  assign w_s2n    = w_signed && src2[W-1];
  assign w_a_mag  = w_s1n ? W'(-src1) : src1;
  assign w_b_mag  = w_s2n ? W'(-src2) : src2;
  assign w_last   = (r_cnt == CW'(ITER - 1));

  // One shift-add multiply step
  assign w_mul_sum = {1'b0, r_acc[2*W-1:W]} + (r_acc[0] ? {1'b0, r_opb} : {(W+1){1'b0}});
  assign w_mul_acc = {w_mul_sum, r_acc[W-1:1]};

  // One restoring divide step; only the low W bits of the difference survive
  assign w_div_ok  = {r_acc[2*W-1:W-1]} >= {1'b0, r_opb};
  assign w_rem_sub = r_acc[2*W-2:W-1] - r_opb;
  assign w_div_acc = w_div_ok ? {w_rem_sub, r_acc[W-2:0], 1'b1} : {r_acc[2*W-2:0], 1'b0};

  assign w_step = (r_state == S_DIV) ? w_div_acc : w_mul_acc;

  // Final-step results with sign restoration, captured straight into the write regs
  assign w_prod   = r_neg_q ? (2*W)'(-w_step) : w_step;
  assign w_quo    = w_step[W-1:0];
  assign w_rem    = w_step[2*W-1:W];
  assign w_hi_res = (r_state == S_MUL) ? w_prod[2*W-1:W] :
                    r_divz ? r_src1 : (r_neg_r ? W'(-w_rem) : w_rem);
  assign w_lo_res = (r_state == S_MUL) ? w_prod[W-1:0] :
                    r_divz ? {W{1'b1}} : (r_neg_q ? W'(-w_quo) : w_quo);

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next state and combinational stall
  always_comb begin
    w_state_nxt = r_state;
    stall       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_go && w_is_md) begin
          stall = 1'b1;
          if (w_is_mul) w_state_nxt = S_MUL;
          else          w_state_nxt = S_DIV;
        end
      end
      S_MUL, S_DIV: begin
        stall = 1'b1;
        if (flush)       w_state_nxt = S_IDLE;
        else if (w_last) w_state_nxt = S_WB;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath, counter and registered HI/LO write port
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt      <= '0;
      r_acc      <= '0;
      r_opb      <= '0;
      r_src1     <= '0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_divz     <= 1'b0;
      r_busy     <= 1'b0;
      r_hi_we    <= 1'b0;
      r_lo_we    <= 1'b0;
      r_hi_wdata <= '0;
      r_lo_wdata <= '0;
    end else begin
      r_hi_we <= 1'b0;
      r_lo_we <= 1'b0;
      r_busy  <= (w_state_nxt == S_MUL) || (w_state_nxt == S_DIV);
      case (r_state)
        S_IDLE: begin
          if (w_go && (op == OP_MTHI)) begin
            r_hi_we    <= 1'b1;
            r_hi_wdata <= src1;
          end
          if (w_go && (op == OP_MTLO)) begin
            r_lo_we    <= 1'b1;
            r_lo_wdata <= src1;
          end
          if (w_go && w_is_md) begin
            r_cnt   <= '0;
            r_acc   <= {{W{1'b0}}, w_a_mag};
            r_opb   <= w_b_mag;
            r_src1  <= src1;
            r_neg_q <= w_s1n ^ w_s2n;
            r_neg_r <= w_s1n;
            r_divz  <= (src2 == '0);
          end
        end
        S_MUL, S_DIV: begin
          if (flush) begin
            r_cnt <= '0;
          end else begin
            r_acc <= w_step;
            r_cnt <= r_cnt + CW'(1);
            if (w_last) begin
              r_hi_we    <= 1'b1;
              r_lo_we    <= 1'b1;
              r_hi_wdata <= w_hi_res;
              r_lo_wdata <= w_lo_res;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy     = r_busy;
  assign hi_we    = r_hi_we;
  assign lo_we    = r_lo_we;
  assign hi_wdata = r_hi_wdata;
  assign lo_wdata = r_lo_wdata;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Scoreboard bench for hilo_muldiv_ctrl: expected HI/LO writes (with the
// cycle they must appear in) are queued at issue and popped when a write
// enable is seen.
module tb_hilo_muldiv_ctrl;

  logic        clk, resetn, start, flush;
  logic [2:0]  op;
  logic [31:0] src1, src2;
  logic        stall, busy, hi_we, lo_we;
  logic [31:0] hi_wdata, lo_wdata;

  typedef struct {
    int          at;
    logic        hwe;
    logic        lwe;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  hilo_muldiv_ctrl #(.ITER(32)) dut (
    .clk(clk), .resetn(resetn), .start(start), .op(op),
    .src1(src1), .src2(src2), .flush(flush),
    .stall(stall), .busy(busy),
    .hi_we(hi_we), .hi_wdata(hi_wdata),
    .lo_we(lo_we), .lo_wdata(lo_wdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [2:0] o, input logic [31:0] a,
                                 input logic [31:0] b, input int at);
    exp_t   e;
    longint sa, sb_;
    logic [63:0] p, r;
    sa  = longint'($signed(a));
    sb_ = longint'($signed(b));
    e.at = at; e.hwe = 1'b1; e.lwe = 1'b1; e.hi = '0; e.lo = '0;
    case (o)
      3'd1: begin p = 64'(sa * sb_); e.hi = p[63:32]; e.lo = p[31:0]; end
      3'd2: begin p = {32'b0, a} * {32'b0, b}; e.hi = p[63:32]; e.lo = p[31:0]; end
      3'd3: begin
        if (b == 0) begin e.hi = a; e.lo = 32'hFFFFFFFF; end
        else begin p = 64'(sa / sb_); r = 64'(sa % sb_); e.hi = r[31:0]; e.lo = p[31:0]; end
      end
      3'd4: begin
        if (b == 0) begin e.hi = a; e.lo = 32'hFFFFFFFF; end
        else begin e.hi = a % b; e.lo = a / b; end
      end
      3'd5: begin e.lwe = 1'b0; e.hi = a; end
      default: begin e.hwe = 1'b0; e.lo = a; end
    endcase
    return e;
  endfunction

  // Write monitor: every write enable must match the head of the scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (resetn && (hi_we || lo_we)) begin
      if (sb.size() == 0) begin
        chk("spurious_wr", {62'b0, hi_we, lo_we}, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("wr_cycle", 64'(cyc), 64'(e.at));
        chk("hi_we", 64'(hi_we), 64'(e.hwe));
        chk("lo_we", 64'(lo_we), 64'(e.lwe));
        if (e.hwe) chk("hi_wdata", 64'(hi_wdata), 64'(e.hi));
        if (e.lwe) chk("lo_wdata", 64'(lo_wdata), 64'(e.lo));
      end
    end
  end

  task automatic idle_in();
    start = 1'b0; op = 3'd0; flush = 1'b0;
  endtask

  // Drive one request in the current (IDLE) cycle; keep=0 marks an op that will be aborted
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input bit fl, input bit keep);
    start = 1'b1; op = o; src1 = a; src2 = b; flush = fl;
    if (keep && !fl && (o >= 3'd1) && (o <= 3'd6))
      sb.push_back(model(o, a, b, cyc + (((o == 3'd5) || (o == 3'd6)) ? 1 : 33)));
    #1;
    chk("acc_stall", 64'(stall), 64'(!fl && (o >= 3'd1) && (o <= 3'd4)));
  endtask

  // Follow a mul/div op through its 32 steps and WB; optional stray start or WB flush
  task automatic follow(input int st_at, input bit wb_flush);
    for (int i = 1; i <= 33; i++) begin
      @(negedge clk);
      idle_in();
      if (i == st_at) begin start = 1'b1; op = 3'd5; src1 = 32'hDEADBEEF; end
      if (wb_flush && i == 33) flush = 1'b1;
      #1;
      chk("run_stall", 64'(stall), 64'(i <= 32));
      chk("run_busy", 64'(busy), 64'(i <= 32));
    end
    @(negedge clk);
    idle_in();
  endtask

  task automatic run_md(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int st_at, input bit wb_flush);
    @(negedge clk);
    issue(o, a, b, 1'b0, 1'b1);
    follow(st_at, wb_flush);
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_stall"}, 64'(stall), 64'd0);
    chk({pfx, "_busy"}, 64'(busy), 64'd0);
    chk({pfx, "_hi_we"}, 64'(hi_we), 64'd0);
    chk({pfx, "_lo_we"}, 64'(lo_we), 64'd0);
    chk({pfx, "_hi_wdata"}, 64'(hi_wdata), 64'd0);
    chk({pfx, "_lo_wdata"}, 64'(lo_wdata), 64'd0);
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    clk = 1'b0; resetn = 1'b0; src1 = '0; src2 = '0;
    idle_in();
    repeat (2) @(negedge clk);
    #1 chk_zero("rst");
    @(negedge clk) resetn = 1'b1;

    // Directed mul/div cases, including stray starts during MUL and WB and a WB flush
    run_md(3'd1, 32'hFFFFFFFE, 32'h00000003, 0, 1'b0);
    run_md(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, 1'b0);
    run_md(3'd3, 32'hFFFFFFF9, 32'h00000002, 33, 1'b0);
    run_md(3'd4, 32'h00000007, 32'h00000002, 0, 1'b1);
    run_md(3'd3, 32'h80000000, 32'hFFFFFFFF, 0, 1'b0);
    run_md(3'd4, 32'h00000005, 32'h00000000, 0, 1'b0);
    run_md(3'd3, 32'hFFFFFFF0, 32'h00000000, 0, 1'b0);

    // Back-to-back MTHI then MTLO
    @(negedge clk); issue(3'd5, 32'h12345678, 32'h0, 1'b0, 1'b1);
    @(negedge clk); issue(3'd6, 32'hCAFEF00D, 32'h0, 1'b0, 1'b1);
    @(negedge clk); idle_in();
    #1 chk("mt_stall", 64'(stall), 64'd0);

    // Flush-cancelled start and reserved ops are ignored
    @(negedge clk); issue(3'd6, 32'h11111111, 32'h0, 1'b1, 1'b1);
    @(negedge clk); issue(3'd7, 32'h22222222, 32'h3, 1'b0, 1'b1);
    @(negedge clk); issue(3'd0, 32'h33333333, 32'h3, 1'b0, 1'b1);
    @(negedge clk); idle_in();
    #1 chk("rsv_busy", 64'(busy), 64'd0);
    repeat (3) @(negedge clk);

    // Flush at iteration 10 of DIV, then a MULT in the very next cycle
    @(negedge clk); issue(3'd3, 32'd100, 32'd7, 1'b0, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk); idle_in();
      if (i == 10) flush = 1'b1;
    end
    #1 chk("flush_stall", 64'(stall), 64'd1);
    @(negedge clk); idle_in();
    #1 chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_idle_stall", 64'(stall), 64'd0);
    issue(3'd1, 32'h00001234, 32'hFFFFFF00, 1'b0, 1'b1);
    follow(0, 1'b0);

    // Random mul/div, including a divide by zero and small divisors
    for (int k = 0; k < 6; k++) begin
      ro = 3'($urandom_range(1, 4));
      ra = $urandom;
      rb = (k == 2) ? 32'd0 : ((k % 2) == 1) ? 32'($urandom_range(1, 15)) : $urandom;
      run_md(ro, ra, rb, 0, 1'b0);
    end

    // Reset at iteration 20 of MULT
    @(negedge clk); issue(3'd1, 32'd12345, 32'd678, 1'b0, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk); idle_in();
    end
    resetn = 1'b0;
    #1 chk_zero("midrst");
    @(negedge clk) resetn = 1'b1;
    repeat (40) @(negedge clk);
    chk("post_rst_busy", 64'(busy), 64'd0);

    repeat (5) @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
